// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, angle-fold constants and the atan table
// (angles use 2^32 = 360 degrees).
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

  localparam logic [31:0] FOLD_MSB = 32'h8000_0000;
  localparam logic [31:0] FOLD_QTR = 32'h4000_0000;

  // atan(2^-i) scaled so that 2^32 is a full turn
  function automatic logic [31:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 32'h2000_0000;
      5'd1:  return 32'h12E4_051E;
      5'd2:  return 32'h09FB_385B;
      5'd3:  return 32'h0511_11D4;
      5'd4:  return 32'h028B_0D43;
      5'd5:  return 32'h0145_D7E1;
      5'd6:  return 32'h00A2_F61E;
      5'd7:  return 32'h0051_7C55;
      5'd8:  return 32'h0028_BE53;
      5'd9:  return 32'h0014_5F2F;
      5'd10: return 32'h000A_2F98;
      5'd11: return 32'h0005_17CC;
      5'd12: return 32'h0002_8BE6;
      5'd13: return 32'h0001_45F3;
      5'd14: return 32'h0000_A2FA;
      5'd15: return 32'h0000_517D;
      5'd16: return 32'h0000_28BE;
      5'd17: return 32'h0000_145F;
      5'd18: return 32'h0000_0A30;
      5'd19: return 32'h0000_0518;
      5'd20: return 32'h0000_028C;
      5'd21: return 32'h0000_0146;
      5'd22: return 32'h0000_00A3;
      5'd23: return 32'h0000_0051;
      5'd24: return 32'h0000_0029;
      5'd25: return 32'h0000_0014;
      5'd26: return 32'h0000_000A;
      5'd27: return 32'h0000_0005;
      5'd28: return 32'h0000_0003;
      5'd29: return 32'h0000_0001;
      5'd30: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Request/response bus of the shared CORDIC scheduler.
interface cordic_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [32*NUM_REQ-1:0]   req_angle;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic signed [WIDTH-1:0] rsp_cos;
  logic signed [WIDTH-1:0] rsp_sin;
  logic                    busy;

  modport slave (
    input  req_valid, req_angle, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_cos, rsp_sin, busy
  );

  modport master (
    output req_valid, req_angle, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_cos, rsp_sin, busy
  );
endinterface

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation (rotation mode, drives z toward 0).
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int XW = 18
) (
  input  logic signed [XW-1:0] x_i,
  input  logic signed [XW-1:0] y_i,
  input  logic signed [31:0]   z_i,
  input  logic [4:0]           i_i,
  output logic signed [XW-1:0] x_o,
  output logic signed [XW-1:0] y_o,
  output logic signed [31:0]   z_o
);
  logic signed [XW-1:0] xs, ys;
  logic signed [31:0]   a;

  always_comb begin
    xs = x_i >>> i_i;
    ys = y_i >>> i_i;
    a  = signed'(atan_lut(i_i));
    if (z_i[31]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + a;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - a;
    end
  end
endmodule

// File: rtl/cordic_sched.sv
// Shares one iterative CORDIC rotator among NUM_REQ requesters.
// Define CORDIC_RR_ARB_EN for round-robin arbitration; default is fixed priority.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ITER    = 16,
  parameter int X_INIT  = 19896
) (
  input logic         clock,
  input logic         reset,
  cordic_sched_if.slave bus
);
  localparam int XW  = WIDTH + 2;
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic signed [XW:0] POS_LIM = (XW+1)'(2**(WIDTH-1) - 1);
  localparam logic signed [XW:0] NEG_LIM = -POS_LIM;

  state_e state_q, state_d;

  logic [NUM_REQ-1:0] gnt, req_ready;
  logic [IDW-1:0]     gid, ptr;
  logic [IDW:0]       arb_s;
  logic               found, accept, last, busy;
  logic [31:0]        ang;

  logic signed [XW-1:0]    x_q, x_d, y_q, y_d, x_n, y_n;
  logic signed [31:0]      z_q, z_d, z_n;
  logic                    neg_q, neg_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic signed [WIDTH-1:0] rsp_cos_q, rsp_cos_d, rsp_sin_q, rsp_sin_d;

  function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [XW-1:0] v,
                                                      input logic n);
    logic signed [XW:0] t;
    t = (XW+1)'(v);
    if (n) t = -t;
    if (t > POS_LIM)      t = POS_LIM;
    else if (t < NEG_LIM) t = NEG_LIM;
    return t[WIDTH-1:0];
  endfunction

`ifdef CORDIC_RR_ARB_EN
  logic [IDW-1:0] rr_q, rr_d;
  logic [IDW:0]   rr_nx;

  assign rr_nx = {1'b0, gid} + (IDW+1)'(1);
  assign ptr   = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (accept) rr_d = (rr_nx >= (IDW+1)'(NUM_REQ)) ? '0 : rr_nx[IDW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`else
  assign ptr = '0;
`endif

  // Search starts at ptr and wraps; first valid requester found wins
  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    arb_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      arb_s = {1'b0, ptr} + (IDW+1)'(k);
      if (arb_s >= (IDW+1)'(NUM_REQ)) arb_s = arb_s - (IDW+1)'(NUM_REQ);
      if (!found && bus.req_valid[arb_s[IDW-1:0]]) begin
        gnt[arb_s[IDW-1:0]] = 1'b1;
        gid   = arb_s[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ang = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt[k]) ang = bus.req_angle[32*k +: 32];
  end

  assign accept = |(bus.req_valid & req_ready);
  assign last   = (cnt_q == 5'(ITER - 1));

  cordic_microrot #(.XW(XW)) u_rot (
    .x_i(x_q), .y_i(y_q), .z_i(z_q), .i_i(cnt_q),
    .x_o(x_n), .y_o(y_n), .z_o(z_n)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ROTATE;
      ROTATE:  if (last) state_d = DONE;
      DONE:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    busy      = 1'b1;
    if (state_q == IDLE) begin
      req_ready = gnt;
      busy      = 1'b0;
    end
  end

  // Angles beyond +/-90 deg are rotated by 180 deg; the result is negated on output
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    neg_d       = neg_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cos_d   = rsp_cos_q;
    rsp_sin_d   = rsp_sin_q;
    case (state_q)
      IDLE: if (accept) begin
        neg_d = |(ang & FOLD_MSB) ^ |(ang & FOLD_QTR);
        z_d   = neg_d ? (ang ^ FOLD_MSB) : ang;
        x_d   = XW'(X_INIT);
        y_d   = '0;
        id_d  = gid;
        cnt_d = '0;
      end
      ROTATE: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        cnt_d = cnt_q + 5'd1;
        if (last) begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_cos_d   = sat_out(x_n, neg_q);
          rsp_sin_d   = sat_out(y_n, neg_q);
        end
      end
      DONE: if (bus.rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      neg_q       <= 1'b0;
      id_q        <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cos_q   <= '0;
      rsp_sin_q   <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cos_q   <= rsp_cos_d;
      rsp_sin_q   <= rsp_sin_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.busy      = busy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_cos   = rsp_cos_q;
  assign bus.rsp_sin   = rsp_sin_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched: angle table, arbitration order, back-pressure
// and mid-job reset.
module tb_cordic_sched;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int ITER    = 16;
  localparam int TOL     = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cordic_sched_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  cordic_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ITER(ITER), .X_INIT(19896)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] ang;
    int          cos_e;
    int          sin_e;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic run_job(input int id, input logic [31:0] ang,
                         output int lat, output int rid, output int c, output int s);
    int w;
    w = 0;
    @(negedge clock);
    bus.req_valid[id] = 1'b1;
    bus.req_angle[32*id +: 32] = ang;
    #1;
    while (!bus.req_ready[id] && w < 50) begin
      @(negedge clock);
      #1;
      w++;
    end
    chk("grant", int'(bus.req_ready[id]), 1, 0);
    @(negedge clock);
    bus.req_valid[id] = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    rid = int'(bus.rsp_id);
    c   = int'(bus.rsp_cos);
    s   = int'(bus.rsp_sin);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rid, c, s, c0, s0, id0, w, n, seen;
    int gids[5];
    int gcyc[5];
    int exp_id;

    vecs[0] = '{0, 32'h0000_0000,  32760,      0};
    vecs[1] = '{1, 32'h2000_0000,  23170,  23170};
    vecs[2] = '{2, 32'h4000_0000,      0,  32764};
    vecs[3] = '{3, 32'h8000_0000, -32764,      0};
    vecs[4] = '{0, 32'hC000_0000,      0, -32764};
    vecs[5] = '{1, 32'h1555_5555,  28375,  16382};
    vecs[6] = '{2, 32'hE000_0000,  23168, -23168};
    vecs[7] = '{3, 32'h6000_0000, -23168,  23168};

    bus.req_valid = '0;
    bus.req_angle = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clock);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0, 0);
    chk("rst_busy",      int'(bus.busy), 0, 0);
    chk("rst_rsp_id",    int'(bus.rsp_id), 0, 0);
    chk("rst_rsp_cos",   int'(bus.rsp_cos), 0, 0);
    chk("rst_rsp_sin",   int'(bus.rsp_sin), 0, 0);
    chk("rst_req_ready", int'(bus.req_ready), 0, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      run_job(vecs[v].id, vecs[v].ang, lat, rid, c, s);
      chk($sformatf("v%0d_latency", v), lat, ITER, 0);
      chk($sformatf("v%0d_id", v), rid, vecs[v].id, 0);
      chk($sformatf("v%0d_cos", v), c, vecs[v].cos_e, TOL);
      chk($sformatf("v%0d_sin", v), s, vecs[v].sin_e, TOL);
    end

    // Back-pressure in DONE with another requester waiting
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    bus.req_valid[2] = 1'b1;
    bus.req_angle[64 +: 32] = 32'h2000_0000;
    #1;
    chk("bp_grant", int'(bus.req_ready), 4, 0);
    @(negedge clock);
    bus.req_valid[2] = 1'b0;
    bus.req_valid[0] = 1'b1;
    bus.req_angle[0 +: 32] = 32'h0000_0000;
    w = 0;
    while (!bus.rsp_valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    c0 = int'(bus.rsp_cos);
    s0 = int'(bus.rsp_sin);
    id0 = int'(bus.rsp_id);
    chk("bp_cos", c0, 23170, TOL);
    chk("bp_sin", s0, 23170, TOL);
    chk("bp_id", id0, 2, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk("bp_hold_valid", int'(bus.rsp_valid), 1, 0);
      chk("bp_hold_cos", int'(bus.rsp_cos), c0, 0);
      chk("bp_hold_sin", int'(bus.rsp_sin), s0, 0);
      chk("bp_hold_id", int'(bus.rsp_id), id0, 0);
      chk("bp_req_ready", int'(bus.req_ready), 0, 0);
      chk("bp_busy", int'(bus.busy), 1, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_valid", int'(bus.rsp_valid), 0, 0);
    chk("bp_release_busy", int'(bus.busy), 0, 0);
    chk("bp_next_grant", int'(bus.req_ready), 1, 0);
    @(negedge clock);
    bus.req_valid[0] = 1'b0;
    w = 0;
    while (!bus.rsp_valid && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("bp_next_id", int'(bus.rsp_id), 0, 0);
    chk("bp_next_cos", int'(bus.rsp_cos), 32760, TOL);
    @(negedge clock);

    // Arbitration with every requester asserted continuously
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) bus.req_angle[32*k +: 32] = 32'h1000_0000;
    bus.req_valid = '1;
    n = 0;
    for (int cyc = 0; cyc < 150 && n < 5; cyc++) begin
      #1;
      if (|bus.req_ready) begin
        chk("arb_onehot", $countones(bus.req_ready), 1, 0);
        for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) gids[n] = k;
        gcyc[n] = cyc;
        n++;
      end
      @(negedge clock);
    end
    chk("arb_count", n, 5, 0);
    for (int k = 0; k < n; k++) begin
`ifdef CORDIC_RR_ARB_EN
      exp_id = k % NUM_REQ;
`else
      exp_id = 0;
`endif
      chk($sformatf("arb_id%0d", k), gids[k], exp_id, 0);
      if (k > 0) chk($sformatf("arb_gap%0d", k), gcyc[k] - gcyc[k-1], ITER + 2, 0);
    end
    bus.req_valid = '0;
    w = 0;
    while (bus.busy && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("arb_drain", int'(bus.busy), 0, 0);

    // Reset in the middle of ROTATE
    run_job(1, 32'h2000_0000, lat, rid, c, s);
    chk("pre_rst_cos", c, 23170, TOL);
    @(negedge clock);
    bus.req_valid[2] = 1'b1;
    bus.req_angle[64 +: 32] = 32'h1000_0000;
    #1;
    chk("mr_grant", int'(bus.req_ready), 4, 0);
    @(negedge clock);
    bus.req_valid[2] = 1'b0;
    repeat (7) @(negedge clock);
    chk("mr_busy_before", int'(bus.busy), 1, 0);
    reset = 1'b1;
    #1;
    chk("mr_rsp_valid", int'(bus.rsp_valid), 0, 0);
    chk("mr_busy", int'(bus.busy), 0, 0);
    chk("mr_rsp_id", int'(bus.rsp_id), 0, 0);
    chk("mr_rsp_cos", int'(bus.rsp_cos), 0, 0);
    chk("mr_rsp_sin", int'(bus.rsp_sin), 0, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (bus.rsp_valid) seen++;
    end
    chk("mr_no_rsp", seen, 0, 0);
    run_job(3, 32'hC000_0000, lat, rid, c, s);
    chk("mr_after_latency", lat, ITER, 0);
    chk("mr_after_id", rid, 3, 0);
    chk("mr_after_cos", c, 0, TOL);
    chk("mr_after_sin", s, -32764, TOL);
    @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
